cmp8_minmax_tracker: RTL and testbench



---
 rtl/cmp8_pkg.sv | 14 +
 rtl/cmp8.sv | 14 +
 rtl/cmp8_minmax_tracker.sv | 168 ++++++++++++++++
 tb/tb_cmp8_minmax_tracker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp8_pkg.sv
// Shared types and defaults for the cmp8 comparator family and its min/max tracker.
package cmp8_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMP_MAX,
    CMP_MIN,
    DONE
  } minmax_state_t;

endpackage

// File: rtl/cmp8.sv
// 8-bit two-flag magnitude comparator: gt_o = a_i > b_i, lt_o = a_i < b_i.
module cmp8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       gt_o,
  output logic       lt_o
);

  always_comb begin
    gt_o = (a_i > b_i);
    lt_o = (a_i < b_i);
  end

endmodule

// File: rtl/cmp8_minmax_tracker.sv
// Frame-level min/max/count tracker driving one external cmp8 comparator.
// Optional per-extreme position outputs are enabled with CMP8_MINMAX_ARGIDX_EN.
module cmp8_minmax_tracker
  import cmp8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count
`ifdef CMP8_MINMAX_ARGIDX_EN
  ,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  minmax_state_t    state_q, state_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

`ifdef CMP8_MINMAX_ARGIDX_EN
  // pos_q is the zero-based position of the sample under comparison; it
  // comes from the pre-increment count so it saturates at CntMax too.
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
`endif

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    last_d    = last_q;
    sample_d  = sample_q;
    max_d     = max_q;
    min_d     = min_q;
    count_d   = count_q;
`ifdef CMP8_MINMAX_ARGIDX_EN
    pos_d     = pos_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`endif
    cmp_a     = sample_q;
    cmp_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing looks acceptable then.
        in_ready = rst_n;
        accept   = in_valid && rst_n;
        if (accept) begin
          sample_d = in_data;
          last_d   = in_last;
          count_d  = (count_q == CntMax) ? count_q : count_q + CntOne;
`ifdef CMP8_MINMAX_ARGIDX_EN
          pos_d    = count_q;
`endif
          if (first_q) begin
            max_d     = in_data;
            min_d     = in_data;
            count_d   = CntOne;
            first_d   = 1'b0;
`ifdef CMP8_MINMAX_ARGIDX_EN
            max_idx_d = '0;
            min_idx_d = '0;
`endif
            state_d   = in_last ? DONE : IDLE;
          end else begin
            state_d = CMP_MAX;
          end
        end
      end
      CMP_MAX: begin
        cmp_b = max_q;
        if (cmp_gt) begin
          max_d     = sample_q;
`ifdef CMP8_MINMAX_ARGIDX_EN
          max_idx_d = pos_q;
`endif
        end
        state_d = CMP_MIN;
      end
      CMP_MIN: begin
        cmp_b = min_q;
        // An illegal gt&lt pair is read as gt only, so it never moves min.
        if (cmp_lt && !cmp_gt) begin
          min_d     = sample_q;
`ifdef CMP8_MINMAX_ARGIDX_EN
          min_idx_d = pos_q;
`endif
        end
        state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          first_d = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
      sample_q  <= '0;
      max_q     <= '0;
      min_q     <= '0;
      count_q   <= '0;
`ifdef CMP8_MINMAX_ARGIDX_EN
      pos_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      last_q    <= last_d;
      sample_q  <= sample_d;
      max_q     <= max_d;
      min_q     <= min_d;
      count_q   <= count_d;
`ifdef CMP8_MINMAX_ARGIDX_EN
      pos_q     <= pos_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;
`ifdef CMP8_MINMAX_ARGIDX_EN
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_cmp8_minmax_tracker.sv
// Self-checking bench for cmp8_minmax_tracker with a cmp8 comparator in the loop.
module tb_cmp8_minmax_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic       cmp_gt;
  logic       cmp_lt;
  logic       real_gt;
  logic       real_lt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic [7:0] out_count;
`ifdef CMP8_MINMAX_ARGIDX_EN
  logic [7:0] out_max_idx;
  logic [7:0] out_min_idx;
`endif
  logic       inj;
  logic       inj_plan;

  int checks   = 0;
  int failures = 0;

  cmp8 u_cmp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .gt_o (real_gt),
    .lt_o (real_lt)
  );

  // inj forces the illegal gt&lt pair onto the tracker's comparator inputs.
  assign cmp_gt = inj ? 1'b1 : real_gt;
  assign cmp_lt = inj ? 1'b1 : real_lt;

  cmp8_minmax_tracker #(
    .WIDTH (8),
    .CNT_W (8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_gt     (cmp_gt),
    .cmp_lt     (cmp_lt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_count  (out_count)
`ifdef CMP8_MINMAX_ARGIDX_EN
    ,
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame statistics from plain arithmetic, timing as
  // "busy cycles left after an accept" and "result pending".
  logic       m_first = 1'b1;
  logic       m_done  = 1'b0;
  logic       m_plast = 1'b0;
  logic [7:0] m_max = 8'd0, m_min = 8'd0, m_sample = 8'd0, m_bmax = 8'd0, m_bmin = 8'd0;
  int         m_cnt = 0, m_pos = 0, m_busy = 0, m_maxi = 0, m_mini = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_first <= 1'b1; m_done <= 1'b0; m_plast <= 1'b0;
      m_max <= 8'd0; m_min <= 8'd0; m_sample <= 8'd0; m_bmax <= 8'd0; m_bmin <= 8'd0;
      m_cnt <= 0; m_pos <= 0; m_busy <= 0; m_maxi <= 0; m_mini <= 0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done  <= 1'b0;
        m_first <= 1'b1;
        m_cnt   <= 0;
      end
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1 && m_plast) m_done <= 1'b1;
    end else if (in_valid) begin
      m_sample <= in_data;
      m_bmax   <= m_max;
      m_bmin   <= m_min;
      if (m_first) begin
        m_max <= in_data; m_min <= in_data; m_cnt <= 1; m_pos <= 1;
        m_maxi <= 0; m_mini <= 0; m_first <= 1'b0; m_done <= in_last;
      end else begin
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        m_pos <= m_pos + 1;
        if (inj_plan || in_data > m_max) begin
          m_max  <= in_data;
          m_maxi <= (m_pos < 255) ? m_pos : 255;
        end
        if (in_data < m_min) begin
          m_min  <= in_data;
          m_mini <= (m_pos < 255) ? m_pos : 255;
        end
        m_busy  <= 2;
        m_plast <= in_last;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, rst_n && !m_done && m_busy == 0});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
    chk("cmp_a", {24'd0, cmp_a}, {24'd0, m_sample});
    chk("cmp_b", {24'd0, cmp_b},
        (m_busy == 2) ? {24'd0, m_bmax} : (m_busy == 1) ? {24'd0, m_bmin} : 32'd0);
    if (m_busy == 0) begin
      chk("out_max", {24'd0, out_max}, {24'd0, m_max});
      chk("out_min", {24'd0, out_min}, {24'd0, m_min});
      chk("out_count", {24'd0, out_count}, m_cnt);
`ifdef CMP8_MINMAX_ARGIDX_EN
      chk("out_max_idx", {24'd0, out_max_idx}, m_maxi);
      chk("out_min_idx", {24'd0, out_min_idx}, m_mini);
`endif
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts falling edges until out_valid is seen; leaves time at that edge.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    inj       = 1'b0;
    inj_plan  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_max", {24'd0, out_max}, 32'd0);
    chk("rst_min", {24'd0, out_min}, 32'd0);
    chk("rst_count", {24'd0, out_count}, 32'd0);
    chk("rst_cmp_a", {24'd0, cmp_a}, 32'd0);
    chk("rst_cmp_b", {24'd0, cmp_b}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Frame 5, 200, 17, 200 with the consumer always ready.
    out_ready = 1'b1;
    send(8'd5, 1'b0);
    send(8'd200, 1'b0);
    send(8'd17, 1'b0);
    send(8'd200, 1'b1);
    wait_result(lat);
    chk("f1_latency", lat, 32'd3);
    chk("f1_max", {24'd0, out_max}, 32'd200);
    chk("f1_min", {24'd0, out_min}, 32'd5);
    chk("f1_count", {24'd0, out_count}, 32'd4);
`ifdef CMP8_MINMAX_ARGIDX_EN
    chk("f1_max_idx", {24'd0, out_max_idx}, 32'd1);
    chk("f1_min_idx", {24'd0, out_min_idx}, 32'd0);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("f1_released", {31'd0, out_valid}, 32'd0);

    // Single-sample frame: result one cycle after accept, no compare cycles.
    send(8'h80, 1'b1);
    wait_result(lat);
    chk("f2_latency", lat, 32'd1);
    chk("f2_max", {24'd0, out_max}, 32'h80);
    chk("f2_min", {24'd0, out_min}, 32'h80);
    chk("f2_count", {24'd0, out_count}, 32'd1);
    handshake();

    // Consumer back-pressure: result must hold for four cycles.
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b1);
    wait_result(lat);
    chk("f3_latency", lat, 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("f3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("f3_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("f3_max", {24'd0, out_max}, 32'hFF);
      chk("f3_min", {24'd0, out_min}, 32'h00);
      chk("f3_count", {24'd0, out_count}, 32'd3);
    end
    handshake();

    // 300 equal samples: count saturates, equal compares never update.
    for (int i = 0; i < 300; i++) send(8'd7, (i == 299));
    wait_result(lat);
    chk("f4_max", {24'd0, out_max}, 32'd7);
    chk("f4_min", {24'd0, out_min}, 32'd7);
    chk("f4_count", {24'd0, out_count}, 32'd255);
`ifdef CMP8_MINMAX_ARGIDX_EN
    chk("f4_max_idx", {24'd0, out_max_idx}, 32'd0);
    chk("f4_min_idx", {24'd0, out_min_idx}, 32'd0);
`endif
    handshake();

    // Asynchronous reset while in CMP_MAX of the second sample.
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_max", {24'd0, out_max}, 32'd0);
    chk("ar_min", {24'd0, out_min}, 32'd0);
    chk("ar_count", {24'd0, out_count}, 32'd0);
    chk("ar_cmp_a", {24'd0, cmp_a}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd9, 1'b0);
    send(8'd3, 1'b1);
    wait_result(lat);
    chk("f5_max", {24'd0, out_max}, 32'd9);
    chk("f5_min", {24'd0, out_min}, 32'd3);
    chk("f5_count", {24'd0, out_count}, 32'd2);
    handshake();

    // Illegal gt&lt in CMP_MAX of sample 30: max forced to 30, min untouched.
    send(8'd10, 1'b0);
    send(8'd50, 1'b0);
    inj_plan = 1'b1;
    send(8'd30, 1'b1);
    inj_plan = 1'b0;
    inj      = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    chk("inj_max_now", {24'd0, out_max}, 32'd30);
    chk("inj_min_now", {24'd0, out_min}, 32'd10);
    wait_result(lat);
    chk("f6_max", {24'd0, out_max}, 32'd30);
    chk("f6_min", {24'd0, out_min}, 32'd10);
    chk("f6_count", {24'd0, out_count}, 32'd3);
`ifdef CMP8_MINMAX_ARGIDX_EN
    chk("f6_max_idx", {24'd0, out_max_idx}, 32'd2);
    chk("f6_min_idx", {24'd0, out_min_idx}, 32'd0);
`endif
    handshake();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
